decode_issue_sb: RTL and testbench
==================================

Name: decode_issue_sb

Overview:
Parametrised decode/issue stage that generalises the fixed-count stall FSM into a per-register scoreboard. It sits between fetch and execute. It holds the architectural register file, reads operands with same-cycle writeback bypass, and blocks issue on RAW/WAW hazards until the pending result writes back on any of NUM_WB ports. Fetch and execute connect through valid/ready handshakes. The block supports a flush and a stall-cycle performance counter.

Parameters:
XLEN, 32, data/pc width
NREG, 32, number of architectural registers (reg 0 reads zero, never pending)
AW, $clog2(NREG), register address width (derived)
NUM_WB, 2, writeback ports (e.g. ALU/mem and long-latency div/shift)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_valid  in  1  decoded instruction offered
in_ready  out  1  stage accepts this cycle
in_insn  in  32  raw instruction (monitor/passthrough)
in_pc  in  XLEN  instruction pc
in_imm  in  XLEN  decoded immediate
in_rs1, in_rs2  in  AW each  source registers
in_use_rs1, in_use_rs2  in  1 each  source actually read
in_rd  in  AW  destination
in_we  in  1  instruction writes rd
out_valid  out  1  issued entry valid
out_ready  in  1  execute accepts
out_insn, out_pc, out_imm  out  32/XLEN/XLEN  registered copies
out_rs1_data, out_rs2_data  out  XLEN each  operand values
out_rd  out  AW  destination
out_we  out  1  destination write
wb_we  in  NUM_WB  per-port write enable
wb_addr  in  NUM_WB*AW  per-port address, packed, port 0 in LSBs
wb_data  in  NUM_WB*XLEN  per-port data, packed
flush  in  1  kill the held output entry
stall_cycles  out  32  count of cycles with in_valid && !in_ready

Behaviour:
- Reset, one cycle, synchronous: out_valid=0. All out_* data fields=0. out_insn=32'h0000006F. pending[]=0. Register file=0. stall_cycles=0. in_ready=0 during reset.
- Register file: NUM_WB write ports. Writes to reg 0 are ignored. If several ports write the same address in one cycle, the highest-index port wins.
- Operand read is combinational from the file plus bypass. If any wb_we[k] && wb_addr[k]==rs && rs!=0, the value comes from wb_data (highest k wins). Reg 0 always reads 0.
- Hazard, per used source: pending[rs] && !clr[rs], where clr[r] = OR over k of (wb_we[k] && wb_addr[k]==r). An unused source never causes a hazard.
- WAW: in_we && pending[in_rd] && !clr[in_rd] is also a hazard.
- slot_free = !out_valid || out_ready.
- in_ready = !reset && !flush && slot_free && !hazard. The hazard term is evaluated on the current in_* fields.
- issue = in_valid && in_ready. On issue, the output register loads all fields in the next cycle and sets out_valid=1. Latency from accept to out_valid is 1 cycle.
- On out_valid && out_ready && !issue, out_valid goes to 0.
- Output fields are stable while out_valid && !out_ready.
- Scoreboard update each cycle: first clear pending[r] for every r with clr[r]. Then, on issue with in_we && in_rd!=0, set pending[in_rd]. If the set and a clear hit the same register in one cycle, the set wins.
- Flush (priority over issue): out_valid becomes 0. If the killed entry had out_we && out_rd!=0, its pending bit is cleared, unless a clear already applies. No issue occurs in that cycle. Entries that left before the flush still write back normally.
- Downstream returns exactly one wb write per issued writing instruction. A wb to a non-pending register only updates the file.
- stall_cycles increments on in_valid && !in_ready && !reset. It wraps 0xFFFFFFFF to 0.
- Reset mid-operation discards the held entry and all pending bits. In-flight wb data arriving after reset is written to the file with no scoreboard effect.

Test Plan:
- Back-to-back independent ops (x1=.., x2=..), out_ready=1 -> one issue per cycle. out_valid is 1 cycle after accept. stall_cycles=0.
- RAW: issue writer rd=5, then reader rs1=5. wb port1 writes x5=0xDEADBEEF 3 cycles later -> reader in_ready=0 for 3 cycles. It accepts in the wb cycle with out_rs1_data=0xDEADBEEF (bypass). stall_cycles=3.
- Dual wb collision: wb_we=2'b11, both addr=7, data 0x11/0x22 -> x7=0x22. Pending[7] cleared.
- Backpressure: out_ready=0 for 4 cycles with out_valid=1 -> in_ready=0, out_* stable. Deassertion accepts the next instruction in the same cycle out_ready rises.
- Flush: held entry rd=9, out_we=1 -> next cycle out_valid=0 and pending[9]=0. A following reader of x9 issues without stalling.
- Reg 0: writer rd=0 then reader rs1=0 -> no pending set, no stall, operand=0, even when wb writes addr 0 with 0xFFFFFFFF.

Source files
------------

// File: rtl/decode_issue_sb.sv
// Decode/issue stage with a per-register scoreboard, writeback bypass and a
// single output slot handed to execute over a valid/ready handshake.
module decode_issue_sb #(
   parameter int XLEN   = 32,
   parameter int NREG   = 32,
   parameter int AW     = $clog2(NREG),
   parameter int NUM_WB = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [31:0]            in_insn,
   input  logic [XLEN-1:0]        in_pc,
   input  logic [XLEN-1:0]        in_imm,
   input  logic [AW-1:0]          in_rs1,
   input  logic [AW-1:0]          in_rs2,
   input  logic                   in_use_rs1,
   input  logic                   in_use_rs2,
   input  logic [AW-1:0]          in_rd,
   input  logic                   in_we,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [31:0]            out_insn,
   output logic [XLEN-1:0]        out_pc,
   output logic [XLEN-1:0]        out_imm,
   output logic [XLEN-1:0]        out_rs1_data,
   output logic [XLEN-1:0]        out_rs2_data,
   output logic [AW-1:0]          out_rd,
   output logic                   out_we,
   input  logic [NUM_WB-1:0]      wb_we,
   input  logic [NUM_WB*AW-1:0]   wb_addr,
   input  logic [NUM_WB*XLEN-1:0] wb_data,
   input  logic                   flush,
   output logic [31:0]            stall_cycles
);

   logic [XLEN-1:0] rf [NREG];
   logic [NREG-1:0] pending;
   logic [NREG-1:0] pend_nxt;
   logic [NREG-1:0] clr;
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic            hazard;
   logic            slot_free;
   logic            issue;
   logic [31:0]     stall_cnt;

   logic            vld_p1;
   logic [31:0]     insn_p1;
   logic [XLEN-1:0] pc_p1;
   logic [XLEN-1:0] imm_p1;
   logic [XLEN-1:0] rs1_p1;
   logic [XLEN-1:0] rs2_p1;
   logic [AW-1:0]   rd_p1;
   logic            we_p1;

   always_comb begin
      clr = '0;
      for (int k = 0; k < NUM_WB; k++)
         if (wb_we[k]) clr[wb_addr[k*AW +: AW]] = 1'b1;
   end

   // Operand read: later ports override earlier ones, so the highest port wins.
   always_comb begin
      rs1_val = rf[in_rs1];
      rs2_val = rf[in_rs2];
      for (int k = 0; k < NUM_WB; k++) begin
         if (wb_we[k] && wb_addr[k*AW +: AW] == in_rs1) rs1_val = wb_data[k*XLEN +: XLEN];
         if (wb_we[k] && wb_addr[k*AW +: AW] == in_rs2) rs2_val = wb_data[k*XLEN +: XLEN];
      end
      if (in_rs1 == '0) rs1_val = '0;
      if (in_rs2 == '0) rs2_val = '0;
   end

   always_comb begin
      hazard    = (in_use_rs1 && pending[in_rs1] && !clr[in_rs1]) ||
                  (in_use_rs2 && pending[in_rs2] && !clr[in_rs2]) ||
                  (in_we      && pending[in_rd]  && !clr[in_rd]);
      slot_free = !vld_p1 || out_ready;
      in_ready  = !reset && !flush && slot_free && !hazard;
      issue     = in_valid && in_ready;
   end

   // Scoreboard: clears first, a killed entry drops its claim, a new issue sets last.
   always_comb begin
      pend_nxt = pending & ~clr;
      if (flush && vld_p1 && we_p1 && rd_p1 != '0) pend_nxt[rd_p1] = 1'b0;
      if (issue && in_we && in_rd != '0) pend_nxt[in_rd] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < NREG; r++) rf[r] <= '0;
      end else begin
         for (int k = 0; k < NUM_WB; k++)
            if (wb_we[k] && wb_addr[k*AW +: AW] != '0)
               rf[wb_addr[k*AW +: AW]] <= wb_data[k*XLEN +: XLEN];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) pending <= '0;
      else       pending <= pend_nxt;
   end

   // Stage p1: issued entry held for execute
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p1  <= 1'b0;
         insn_p1 <= 32'h0000_006F;
         pc_p1   <= '0;
         imm_p1  <= '0;
         rs1_p1  <= '0;
         rs2_p1  <= '0;
         rd_p1   <= '0;
         we_p1   <= 1'b0;
      end else if (flush) begin
         vld_p1  <= 1'b0;
      end else if (issue) begin
         vld_p1  <= 1'b1;
         insn_p1 <= in_insn;
         pc_p1   <= in_pc;
         imm_p1  <= in_imm;
         rs1_p1  <= rs1_val;
         rs2_p1  <= rs2_val;
         rd_p1   <= in_rd;
         we_p1   <= in_we;
      end else if (vld_p1 && out_ready) begin
         vld_p1  <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)                     stall_cnt <= '0;
      else if (in_valid && !in_ready) stall_cnt <= stall_cnt + 32'd1;
   end

   assign out_valid    = vld_p1;
   assign out_insn     = insn_p1;
   assign out_pc       = pc_p1;
   assign out_imm      = imm_p1;
   assign out_rs1_data = rs1_p1;
   assign out_rs2_data = rs2_p1;
   assign out_rd       = rd_p1;
   assign out_we       = we_p1;
   assign stall_cycles = stall_cnt;

endmodule

// File: tb/tb_decode_issue_sb.sv
// Randomised and directed bench for decode_issue_sb; the reference model
// tracks outstanding writers as a set of in-flight destinations.
module tb_decode_issue_sb;
   localparam int XLEN = 32, NREG = 32, AW = 5, NUM_WB = 2;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   in_valid, in_ready;
   logic [31:0]            in_insn;
   logic [XLEN-1:0]        in_pc, in_imm;
   logic [AW-1:0]          in_rs1, in_rs2, in_rd;
   logic                   in_use_rs1, in_use_rs2, in_we;
   logic                   out_valid, out_ready;
   logic [31:0]            out_insn;
   logic [XLEN-1:0]        out_pc, out_imm, out_rs1_data, out_rs2_data;
   logic [AW-1:0]          out_rd;
   logic                   out_we;
   logic [NUM_WB-1:0]      wb_we;
   logic [NUM_WB*AW-1:0]   wb_addr;
   logic [NUM_WB*XLEN-1:0] wb_data;
   logic                   flush;
   logic [31:0]            stall_cycles;

   always #5 clk = ~clk;

   decode_issue_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NUM_WB(NUM_WB)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn), .in_pc(in_pc),
      .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_rs1(in_use_rs1),
      .in_use_rs2(in_use_rs2), .in_rd(in_rd), .in_we(in_we),
      .out_valid(out_valid), .out_ready(out_ready), .out_insn(out_insn), .out_pc(out_pc),
      .out_imm(out_imm), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
      .out_rd(out_rd), .out_we(out_we),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .flush(flush), .stall_cycles(stall_cycles)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: architectural file, held slot, and destinations still owed a writeback.
   logic [31:0] rf_m [NREG];
   bit          s_vld, s_we;
   logic [31:0] s_insn, s_pc, s_imm, s_a, s_b;
   logic [4:0]  s_rd;
   int          inflight[$];
   logic [31:0] stall_m;

   function automatic void model_reset();
      for (int r = 0; r < NREG; r++) rf_m[r] = '0;
      s_vld = 0; s_we = 0; s_insn = 32'h0000_006F;
      s_pc = '0; s_imm = '0; s_a = '0; s_b = '0; s_rd = '0;
      inflight.delete();
      stall_m = '0;
   endfunction

   function automatic bit is_pending(input int r);
      if (r == 0) return 0;
      if (s_vld && s_we && int'(s_rd) == r) return 1;
      foreach (inflight[i]) if (inflight[i] == r) return 1;
      return 0;
   endfunction

   function automatic bit wb_hits(input int r);
      for (int k = 0; k < NUM_WB; k++)
         if (wb_we[k] && int'(wb_addr[k*AW +: AW]) == r) return 1;
      return 0;
   endfunction

   function automatic logic [31:0] operand(input int r);
      logic [31:0] v;
      if (r == 0) return '0;
      v = rf_m[r];
      for (int k = 0; k < NUM_WB; k++)
         if (wb_we[k] && int'(wb_addr[k*AW +: AW]) == r) v = wb_data[k*XLEN +: XLEN];
      return v;
   endfunction

   function automatic bit exp_ready();
      bit blocked;
      blocked = (in_use_rs1 && is_pending(int'(in_rs1)) && !wb_hits(int'(in_rs1))) ||
                (in_use_rs2 && is_pending(int'(in_rs2)) && !wb_hits(int'(in_rs2))) ||
                (in_we      && is_pending(int'(in_rd))  && !wb_hits(int'(in_rd)));
      return !reset && !flush && (!s_vld || out_ready) && !blocked;
   endfunction

   task automatic step();
      bit er, dep;
      logic [31:0] a, b;
      int ad;
      #1;
      er = exp_ready();
      chk("in_ready",  32'(in_ready), 32'(er));
      chk("out_valid", 32'(out_valid), 32'(s_vld));
      chk("out_insn",  out_insn, s_insn);
      chk("out_pc",    out_pc, s_pc);
      chk("out_imm",   out_imm, s_imm);
      chk("out_rs1",   out_rs1_data, s_a);
      chk("out_rs2",   out_rs2_data, s_b);
      chk("out_rd",    32'(out_rd), 32'(s_rd));
      chk("out_we",    32'(out_we), 32'(s_we));
      chk("stall",     stall_cycles, stall_m);
      a = operand(int'(in_rs1));
      b = operand(int'(in_rs2));
      @(posedge clk);
      if (reset) begin
         model_reset();
      end else begin
         if (in_valid && !er) stall_m++;
         for (int k = 0; k < NUM_WB; k++) begin
            if (wb_we[k]) begin
               ad = int'(wb_addr[k*AW +: AW]);
               for (int i = inflight.size() - 1; i >= 0; i--)
                  if (inflight[i] == ad) inflight.delete(i);
               if (ad != 0) rf_m[ad] = wb_data[k*XLEN +: XLEN];
            end
         end
         dep = s_vld && out_ready && !flush;
         if (dep && s_we && s_rd != 0) inflight.push_back(int'(s_rd));
         if (flush) s_vld = 0;
         else if (in_valid && er) begin
            s_vld = 1; s_insn = in_insn; s_pc = in_pc; s_imm = in_imm;
            s_a = a; s_b = b; s_rd = in_rd; s_we = in_we;
         end else if (dep) s_vld = 0;
      end
      @(negedge clk);
   endtask

   task automatic offer(input bit v, input int rs1, input bit u1, input int rs2,
                        input bit u2, input int rd, input bit we);
      in_valid = v; in_insn = $urandom; in_pc = $urandom; in_imm = $urandom;
      in_rs1 = AW'(rs1); in_use_rs1 = u1; in_rs2 = AW'(rs2); in_use_rs2 = u2;
      in_rd = AW'(rd); in_we = we;
   endtask

   task automatic no_wb();
      wb_we = '0; wb_addr = '0; wb_data = '0;
   endtask

   task automatic set_wb(input int k, input int addr, input logic [31:0] d);
      wb_we[k] = 1'b1;
      wb_addr[k*AW +: AW] = AW'(addr);
      wb_data[k*XLEN +: XLEN] = d;
   endtask

   task automatic rand_wb();
      int used, i, r;
      used = -1;
      no_wb();
      for (int k = 0; k < NUM_WB; k++) begin
         if (inflight.size() > 0 && $urandom_range(0, 2) == 0) begin
            i = $urandom_range(0, inflight.size() - 1);
            if (i != used) begin set_wb(k, inflight[i], $urandom); used = i; end
         end else if ($urandom_range(0, 7) == 0) begin
            r = $urandom_range(0, NREG - 1);
            if (!is_pending(r)) set_wb(k, r, $urandom);
         end
      end
   endtask

   task automatic drain();
      offer(0, 0, 0, 0, 0, 0, 0); out_ready = 1; flush = 0; no_wb();
      step();
      for (int n = 0; n < 40 && inflight.size() > 0; n++) begin
         no_wb();
         set_wb(0, inflight[0], $urandom);
         if (inflight.size() > 1) set_wb(1, inflight[1], $urandom);
         step();
      end
      no_wb();
      chk("drain_empty", 32'(inflight.size()), 32'd0);
   endtask

   logic [31:0] base, pc_a, pc_b;

   initial begin
      reset = 1; out_ready = 1; flush = 0;
      offer(1, 0, 0, 0, 0, 1, 1); no_wb();
      @(posedge clk);
      model_reset();
      @(negedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_insn", out_insn, 32'h0000_006F);
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_stall", stall_cycles, 32'd0);
      step();
      reset = 0;

      // independent back-to-back writers
      offer(1, 0, 0, 0, 0, 1, 1); #1 chk("b2b_rdy", 32'(in_ready), 32'd1); step();
      chk("b2b_vld", 32'(out_valid), 32'd1);
      offer(1, 0, 0, 0, 0, 2, 1); step();
      offer(1, 3, 1, 4, 1, 6, 1); step();
      chk("b2b_stall", stall_cycles, 32'd0);
      drain();

      // RAW on x5, resolved by a port-1 writeback three cycles later
      base = stall_m;
      offer(1, 0, 0, 0, 0, 5, 1); step();
      offer(1, 5, 1, 0, 0, 10, 1);
      repeat (3) begin #1 chk("raw_block", 32'(in_ready), 32'd0); step(); end
      set_wb(1, 5, 32'hDEAD_BEEF);
      #1 chk("raw_accept", 32'(in_ready), 32'd1);
      step(); no_wb();
      chk("raw_bypass", out_rs1_data, 32'hDEAD_BEEF);
      chk("raw_stalls", stall_cycles - base, 32'd3);
      drain();

      // both ports write x7 in the same cycle
      offer(1, 0, 0, 0, 0, 7, 1); step();
      offer(0, 0, 0, 0, 0, 0, 0); step();
      set_wb(0, 7, 32'h11); set_wb(1, 7, 32'h22); step(); no_wb();
      offer(1, 7, 1, 0, 0, 0, 0); #1 chk("dual_rdy", 32'(in_ready), 32'd1); step();
      chk("dual_val", out_rs1_data, 32'h22);
      drain();

      // backpressure holds the slot and blocks input
      offer(1, 0, 0, 0, 0, 11, 1); pc_a = in_pc; step();
      out_ready = 0; offer(1, 1, 1, 0, 0, 12, 1); pc_b = in_pc;
      repeat (4) begin
         #1 chk("bp_block", 32'(in_ready), 32'd0);
         step();
         chk("bp_hold", out_pc, pc_a);
      end
      out_ready = 1;
      #1 chk("bp_accept", 32'(in_ready), 32'd1);
      step();
      chk("bp_next", out_pc, pc_b);
      drain();

      // flush kills a held writer of x9 and releases its scoreboard claim
      offer(1, 0, 0, 0, 0, 9, 1); step();
      out_ready = 0; flush = 1; offer(0, 0, 0, 0, 0, 0, 0); step();
      flush = 0;
      chk("fl_vld", 32'(out_valid), 32'd0);
      out_ready = 1; offer(1, 9, 1, 0, 0, 0, 0);
      #1 chk("fl_rdy", 32'(in_ready), 32'd1);
      step();
      drain();

      // x0 is never pending and always reads zero
      offer(1, 0, 0, 0, 0, 0, 1); step();
      offer(1, 0, 1, 0, 1, 0, 0); set_wb(0, 0, 32'hFFFF_FFFF);
      #1 chk("r0_rdy", 32'(in_ready), 32'd1);
      step(); no_wb();
      chk("r0_op1", out_rs1_data, 32'd0);
      chk("r0_op2", out_rs2_data, 32'd0);
      drain();

      // randomised traffic
      repeat (2000) begin
         out_ready = ($urandom_range(0, 3) != 0);
         flush = ($urandom_range(0, 15) == 0);
         offer($urandom_range(0, 3) != 0, $urandom_range(0, 7), 1'($urandom),
               $urandom_range(0, 7), 1'($urandom), $urandom_range(0, 7), 1'($urandom));
         rand_wb();
         step();
      end

      // reset mid-operation, then a late writeback lands without scoreboard effect
      flush = 0; no_wb(); reset = 1;
      offer(1, 1, 1, 2, 1, 3, 1);
      step();
      reset = 0;
      chk("mid_rst_vld", 32'(out_valid), 32'd0);
      offer(0, 0, 0, 0, 0, 0, 0); out_ready = 1;
      set_wb(0, 3, 32'hA5A5_0003); step(); no_wb();
      offer(1, 3, 1, 0, 0, 3, 1);
      #1 chk("post_rst_rdy", 32'(in_ready), 32'd1);
      step();
      chk("post_rst_val", out_rs1_data, 32'hA5A5_0003);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
